// File: rtl/regfile_sb.sv
// ---------------------------------------------------------------------------
// regfile_sb
//
// Decode-stage register file with a per-entry pending (busy) scoreboard and a
// self-clearing initialisation walk.
//
// After reset the block walks every entry once, writing zero to one entry
// per clock (state CLEAR).  Only when the last entry has been cleared does it
// enter READY and accept writes and reserves.  This avoids a single-cycle
// reset of the whole array.
//
// Parameters
//   DATA_W    width of each register
//   ADDR_W    address width, DEPTH = 2**ADDR_W entries
//   ZERO_REG  1: entry 0 reads as zero, is never pending, and drops writes
//             and reserves
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high
//   rd_addr1/2 read addresses
//   rd_data1/2 combinational read data (0 while clearing)
//   rd_busy1/2 pending bit of the addressed entry (0 while clearing)
//   wr_en      write strobe: wr_data -> entry wr_addr, clears its pending bit
//   wr_addr    write address
//   wr_data    write data
//   rsv_en     reserve strobe: marks rsv_addr pending (in-flight producer)
//   rsv_addr   reserve address
//   ready      high once the initial clear walk is complete
//   dbg_state  current FSM state (0 = CLEAR, 1 = READY)
//
// Request semantics: wr_en and rsv_en are single-cycle strobes with no
// backpressure.  In READY every strobe completes at the edge it is sampled;
// in CLEAR strobes are dropped.  'ready' is the only indication of when
// strobes will be honoured.
//
// Configuration
//   REGFILE_BYPASS_EN  when defined, a write in READY is forwarded to any
//                      read port addressing the same entry in the same cycle.
// ---------------------------------------------------------------------------
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_busy1,
    output logic              rd_busy2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              ready,
    output logic              dbg_state
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    typedef struct packed {
        logic              busy;
        logic [DATA_W-1:0] data;
    } rd_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  clr_ptr_q, clr_ptr_d;
    logic [DEPTH-1:0]   pending_q, pending_d;

    logic [DATA_W-1:0]  mem [DEPTH];
    logic               mem_we;
    logic [ADDR_W-1:0]  mem_waddr;
    logic [DATA_W-1:0]  mem_wdata;

    rd_t                rd1, rd2;

    // True when addr is the hardwired zero entry.
    function automatic logic is_zero(input logic [ADDR_W-1:0] addr);
        return (ZERO_REG != 0) && (addr == '0);
    endfunction

    // ---------------------------------------------------------------------
    // State register (FSM, walk pointer, scoreboard)
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= CLEAR;
            clr_ptr_q <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            pending_q <= pending_d;
        end
    end

    // ---------------------------------------------------------------------
    // Next state, array write port and scoreboard update
    // ---------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        pending_d = pending_q;
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;

        case (state_q)
            CLEAR: begin
                // The walk owns the write port; user strobes are dropped.
                mem_we    = 1'b1;
                mem_waddr = clr_ptr_q;
                mem_wdata = '0;
                clr_ptr_d = clr_ptr_q + 1'b1;
                if (clr_ptr_q == LAST_PTR) begin
                    state_d = READY;
                end
            end
            READY: begin
                if (wr_en && !is_zero(wr_addr)) begin
                    mem_we             = 1'b1;
                    pending_d[wr_addr] = 1'b0;
                end
                // Applied after the write clear so that a reserve on the
                // same entry in the same cycle leaves it pending.
                if (rsv_en && !is_zero(rsv_addr)) begin
                    pending_d[rsv_addr] = 1'b1;
                end
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Storage array: no reset, contents are established by the CLEAR walk.
    // An edge with reset high writes nothing.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset && mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // ---------------------------------------------------------------------
    // Read ports
    // ---------------------------------------------------------------------
    function automatic rd_t read_port(input logic [ADDR_W-1:0] addr);
        rd_t r;
        r.data = '0;
        r.busy = 1'b0;
        if (state_q == READY && !is_zero(addr)) begin
            r.data = mem[addr];
            r.busy = pending_q[addr];
`ifdef REGFILE_BYPASS_EN
            // Forward the write being performed this cycle.  The entry is
            // about to become non-pending unless it is reserved again now.
            if (wr_en && wr_addr == addr) begin
                r.data = wr_data;
                r.busy = rsv_en && (rsv_addr == addr);
            end
`endif
        end
        return r;
    endfunction

    always_comb begin
        rd1 = read_port(rd_addr1);
        rd2 = read_port(rd_addr2);
    end

    assign rd_data1  = rd1.data;
    assign rd_busy1  = rd1.busy;
    assign rd_data2  = rd2.data;
    assign rd_busy2  = rd2.busy;
    assign ready     = (state_q == READY);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;

  localparam int DEPTH = 32;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic [4:0]  rd_addr1 = '0, rd_addr2 = '0;
  logic        wr_en = 1'b0, rsv_en = 1'b0;
  logic [4:0]  wr_addr = '0, rsv_addr = '0;
  logic [31:0] wr_data = '0;

  // index 0: ZERO_REG=1 instance, index 1: ZERO_REG=0 instance
  logic [31:0] d1 [2], d2 [2];
  logic        b1 [2], b2 [2], rdy [2], dbg [2];

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
    .clk(clk), .reset(reset),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(d1[0]), .rd_data2(d2[0]), .rd_busy1(b1[0]), .rd_busy2(b2[0]),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .ready(rdy[0]), .dbg_state(dbg[0])
  );

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0)) dut_nz (
    .clk(clk), .reset(reset),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(d1[1]), .rd_data2(d2[1]), .rd_busy1(b1[1]), .rd_busy2(b2[1]),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .ready(rdy[1]), .dbg_state(dbg[1])
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The clear walk is modelled only as "edges since reset released"; the
  // array is all zero once DEPTH such edges have passed.
  int          m_walk = 0;
  logic [31:0] m_mem  [2][DEPTH];
  bit          m_pend [2][DEPTH];

  function automatic bit m_zero(int k, logic [4:0] a);
    return (k == 0) && (a == 5'd0);
  endfunction

  function automatic void exp_read(input int k, input logic [4:0] a,
                                   output logic [31:0] d, output logic b);
    d = '0;
    b = 1'b0;
    if (m_walk >= DEPTH && !m_zero(k, a)) begin
      d = m_mem[k][a];
      b = m_pend[k][a];
      if (BYPASS && wr_en && wr_addr == a) begin
        d = wr_data;
        b = rsv_en && (rsv_addr == a);
      end
    end
  endfunction

  task automatic model_check();
    logic [31:0] ed;
    logic        eb;
    for (int k = 0; k < 2; k++) begin
      exp_read(k, rd_addr1, ed, eb);
      check($sformatf("m%0d.data1[%0d]", k, rd_addr1), d1[k], ed);
      check($sformatf("m%0d.busy1[%0d]", k, rd_addr1), b1[k], eb);
      exp_read(k, rd_addr2, ed, eb);
      check($sformatf("m%0d.data2[%0d]", k, rd_addr2), d2[k], ed);
      check($sformatf("m%0d.busy2[%0d]", k, rd_addr2), b2[k], eb);
      check($sformatf("m%0d.ready", k), rdy[k], (m_walk >= DEPTH));
      check($sformatf("m%0d.dbg_state", k), dbg[k], (m_walk >= DEPTH));
    end
  endtask

  task automatic model_update();
    if (reset) begin
      m_walk = 0;
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < DEPTH; i++) m_pend[k][i] = 1'b0;
    end else if (m_walk < DEPTH) begin
      m_walk++;
      if (m_walk == DEPTH)
        for (int k = 0; k < 2; k++)
          for (int i = 0; i < DEPTH; i++) m_mem[k][i] = '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (wr_en && !m_zero(k, wr_addr)) begin
          m_mem[k][wr_addr]  = wr_data;
          m_pend[k][wr_addr] = 1'b0;
        end
        if (rsv_en && !m_zero(k, rsv_addr)) m_pend[k][rsv_addr] = 1'b1;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic half_check();
    @(negedge clk);
    model_check();
  endtask

  task automatic half_edge();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic cycle();
    half_check();
    half_edge();
  endtask

  task automatic idle();
    wr_en = 1'b0;
    rsv_en = 1'b0;
  endtask

  // Run until ready, bounded; returns number of edges taken.
  task automatic walk(output int n);
    n = 0;
    while (!rdy[0] && n < 40) begin
      cycle();
      n++;
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic [4:0]  ra1, ra2;
    logic [31:0] e_d1;
    logic        e_b1;
    logic [31:0] e_d2;
    logic        e_b2;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int n;
    logic [31:0] exp_first;

    // Expected outputs are for the ZERO_REG=1 instance in the cycle the
    // record is applied; no record reads an entry it writes that cycle.
    vecs[0] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd5, 5'd5, 5'd5, 32'h0,        1'b0, 32'h0,  1'b0};
    vecs[1] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd5, 5'd0, 32'h0,        1'b1, 32'h0,  1'b0};
    vecs[2] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0,        1'b0, 32'h0,  1'b0};
    vecs[3] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd5, 5'd5, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0};
    vecs[4] = '{1'b1, 5'd7,  32'h11,       1'b1, 5'd7, 5'd0, 5'd0, 32'h0,        1'b0, 32'h0,  1'b0};
    vecs[5] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd7, 5'd7, 32'h11,       1'b1, 32'h11, 1'b1};
    vecs[6] = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b1, 5'd0, 5'd5, 5'd7, 32'hDEADBEEF, 1'b0, 32'h11, 1'b1};
    vecs[7] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd0, 5'd0, 32'h0,        1'b0, 32'h0,  1'b0};
    vecs[8] = '{1'b1, 5'd7,  32'h22,       1'b0, 5'd0, 5'd5, 5'd0, 32'hDEADBEEF, 1'b0, 32'h0,  1'b0};
    vecs[9] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 5'd7, 5'd0, 32'h22,       1'b0, 32'h0,  1'b0};

    // ---- reset: two edges high, then the clear walk ----
    reset = 1'b1;
    @(posedge clk);
    model_update();
    #1;
    cycle();
    reset = 1'b0;
    walk(n);
    check("clear_walk_edges", n, 32);

    // ---- every entry reads zero and idle after the walk ----
    for (int i = 0; i < DEPTH; i++) begin
      rd_addr1 = 5'(i);
      rd_addr2 = 5'(DEPTH - 1 - i);
      half_check();
      check($sformatf("post_clear_data[%0d]", i), d1[1], 32'h0);
      check($sformatf("post_clear_busy[%0d]", i), b1[1], 1'b0);
      half_edge();
    end

    // ---- directed table ----
    for (int v = 0; v < 10; v++) begin
      wr_en = vecs[v].wr_en;  wr_addr = vecs[v].wr_addr;  wr_data = vecs[v].wr_data;
      rsv_en = vecs[v].rsv_en; rsv_addr = vecs[v].rsv_addr;
      rd_addr1 = vecs[v].ra1; rd_addr2 = vecs[v].ra2;
      half_check();
      check($sformatf("vec%0d.data1", v), d1[0], vecs[v].e_d1);
      check($sformatf("vec%0d.busy1", v), b1[0], vecs[v].e_b1);
      check($sformatf("vec%0d.data2", v), d2[0], vecs[v].e_d2);
      check($sformatf("vec%0d.busy2", v), b2[0], vecs[v].e_b2);
      half_edge();
    end
    idle();

    // ---- r0 on the ZERO_REG=0 instance holds the write and reserve ----
    rd_addr1 = 5'd0;
    half_check();
    check("nz_r0_data", d1[1], 32'hFFFFFFFF);
    check("nz_r0_busy", b1[1], 1'b1);
    check("zr_r0_data", d1[0], 32'h0);
    half_edge();

    // ---- same-cycle write to a read address ----
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hA5A5A5A5; rd_addr1 = 5'd3;
    exp_first = BYPASS ? 32'hA5A5A5A5 : 32'h0;
    half_check();
    check("bypass_same_cycle", d1[0], exp_first);
    half_edge();
    idle();
    half_check();
    check("bypass_next_cycle", d1[0], 32'hA5A5A5A5);
    half_edge();
    // write + reserve on a read address
    wr_en = 1'b1; rsv_en = 1'b1; wr_addr = 5'd3; rsv_addr = 5'd3; wr_data = 32'h5;
    cycle();
    idle();
    cycle();

    // ---- reset in the middle of the clear walk ----
    wr_en = 1'b1; wr_addr = 5'd20; wr_data = 32'h55; rd_addr1 = 5'd20;
    cycle();
    idle();
    half_check();
    check("r20_before_reset", d1[0], 32'h55);
    half_edge();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    wr_en = 1'b1; wr_addr = 5'd20; wr_data = 32'h77;
    repeat (9) cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    walk(n);
    check("reclear_walk_edges", n, 32);
    idle();
    half_check();
    check("r20_after_reclear", d1[0], 32'h0);
    check("r20_busy_after_reclear", b1[0], 1'b0);
    half_edge();

    // ---- randomized traffic against the model ----
    for (int c = 0; c < 1500; c++) begin
      reset    = ($urandom_range(0, 299) == 0);
      wr_en    = $urandom_range(0, 1);
      rsv_en   = ($urandom_range(0, 2) == 0);
      wr_addr  = 5'($urandom_range(0, 7));
      rsv_addr = 5'($urandom_range(0, 7));
      wr_data  = $urandom;
      rd_addr1 = 5'($urandom_range(0, 7));
      rd_addr2 = ($urandom_range(0, 3) == 0) ? rd_addr1 : 5'($urandom_range(0, 31));
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
